// File: rtl/exe_pkg.sv
// Shared definitions for the EX stage: ALU op codes, FSM state encoding and width defaults.
package exe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [2:0] EXE_ADD = 3'b000;
  localparam logic [2:0] EXE_SUB = 3'b001;
  localparam logic [2:0] EXE_AND = 3'b010;
  localparam logic [2:0] EXE_OR  = 3'b011;
  localparam logic [2:0] EXE_XOR = 3'b100;
  localparam logic [2:0] EXE_SLT = 3'b101;
  localparam logic [2:0] EXE_SLL = 3'b110;
  localparam logic [2:0] EXE_MUL = 3'b111;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
endpackage

// File: rtl/exe_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles per operation.
module seq_multiplier
  import exe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CW = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_next;
  logic              last;

  assign last     = (cnt_q == CW'(DATA_W - 1));
  assign acc_next = b_q[0] ? acc_q + a_q : acc_q;
  assign busy     = (state_q == ST_BUSY);
  // Final partial product is folded in combinationally so the result is ready on the last edge.
  assign done     = busy && !flush && last;
  assign product  = acc_next;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_next;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/exe_stage.sv
// EX pipeline stage: single-cycle ALU plus iterative MUL, registering the EX/MEM bundle.
module exe_stage
  import exe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        exe_cmd,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic              m_in,
  input  logic [1:0]        wb_in,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] sign_ex,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [REG_AW-1:0] dest1,
  input  logic [REG_AW-1:0] dest2,
  input  logic              flush,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_AW-1:0] dest_out,
  output logic              m_out,
  output logic [1:0]        wb_out,
  output logic [DATA_W-1:0] pc_out
);
  localparam int SH_W = $clog2(DATA_W);

  logic signed [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0]        alu_res;
  logic                     accept, mul_start, mul_busy, mul_done;
  logic [DATA_W-1:0]        mul_product;

  logic              out_valid_q, out_valid_d, m_q, m_d, m_pend_q, m_pend_d;
  logic [1:0]        wb_q, wb_d, wb_pend_q, wb_pend_d;
  logic [DATA_W-1:0] alu_q, alu_d, store_q, store_d, pc_q, pc_d;
  logic [REG_AW-1:0] dest_q, dest_d;

  assign op_a      = read_data1;
  assign op_b      = alu_src ? sign_ex : read_data2;
  assign accept    = !mul_busy && in_valid && !flush;
  assign mul_start = accept && (exe_cmd == EXE_MUL);

  always_comb begin
    alu_res = '0;
    case (exe_cmd)
      EXE_ADD: alu_res = op_a + op_b;
      EXE_SUB: alu_res = op_a - op_b;
      EXE_AND: alu_res = op_a & op_b;
      EXE_OR:  alu_res = op_a | op_b;
      EXE_XOR: alu_res = op_a ^ op_b;
      EXE_SLT: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      EXE_SLL: alu_res = op_a << op_b[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .flush   (flush),
    .a       (read_data1),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    alu_d       = alu_q;
    store_d     = store_q;
    pc_d        = pc_q;
    dest_d      = dest_q;
    m_d         = m_q;
    wb_d        = wb_q;
    m_pend_d    = m_pend_q;
    wb_pend_d   = wb_pend_q;
    if (mul_busy) begin
      if (flush) begin
        out_valid_d = 1'b0;
        m_d         = 1'b0;
        wb_d        = '0;
      end else if (mul_done) begin
        out_valid_d = 1'b1;
        alu_d       = mul_product;
        m_d         = m_pend_q;
        wb_d        = wb_pend_q;
      end
    end else if (accept) begin
      store_d   = read_data2;
      pc_d      = pc_in;
      dest_d    = reg_dst ? dest2 : dest1;
      m_pend_d  = m_in;
      wb_pend_d = wb_in;
      // MUL parks its control bits until the product is ready.
      if (mul_start) begin
        out_valid_d = 1'b0;
        m_d         = 1'b0;
        wb_d        = '0;
      end else begin
        out_valid_d = 1'b1;
        alu_d       = alu_res;
        m_d         = m_in;
        wb_d        = wb_in;
      end
    end else begin
      out_valid_d = 1'b0;
      m_d         = 1'b0;
      wb_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      alu_q       <= '0;
      store_q     <= '0;
      pc_q        <= '0;
      dest_q      <= '0;
      m_q         <= 1'b0;
      wb_q        <= '0;
      m_pend_q    <= 1'b0;
      wb_pend_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_q       <= alu_d;
      store_q     <= store_d;
      pc_q        <= pc_d;
      dest_q      <= dest_d;
      m_q         <= m_d;
      wb_q        <= wb_d;
      m_pend_q    <= m_pend_d;
      wb_pend_q   <= wb_pend_d;
    end
  end

  assign stall      = mul_busy;
  assign out_valid  = out_valid_q;
  assign alu_result = alu_q;
  assign store_data = store_q;
  assign pc_out     = pc_q;
  assign dest_out   = dest_q;
  assign m_out      = m_q;
  assign wb_out     = wb_q;
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: reset, ALU ops, iterative MUL, bubbles, flush and mid-MUL reset.
module tb_exe_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, alu_src, reg_dst, m_in, flush;
  logic [2:0]  exe_cmd;
  logic [1:0]  wb_in;
  logic [31:0] read_data1, read_data2, sign_ex, pc_in;
  logic [4:0]  dest1, dest2;
  logic        stall, out_valid, m_out;
  logic [31:0] alu_result, store_data, pc_out;
  logic [4:0]  dest_out;
  logic [1:0]  wb_out;

  int checks   = 0;
  int failures = 0;
  int cnt;

  exe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .exe_cmd(exe_cmd), .alu_src(alu_src),
    .reg_dst(reg_dst), .m_in(m_in), .wb_in(wb_in), .read_data1(read_data1),
    .read_data2(read_data2), .sign_ex(sign_ex), .pc_in(pc_in), .dest1(dest1),
    .dest2(dest2), .flush(flush), .stall(stall), .out_valid(out_valid),
    .alu_result(alu_result), .store_data(store_data), .dest_out(dest_out),
    .m_out(m_out), .wb_out(wb_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] se, input logic src,
                       input logic rd, input logic m, input logic [1:0] wb,
                       input logic [31:0] pc, input logic fl);
    in_valid = v; exe_cmd = cmd; read_data1 = a; read_data2 = b; sign_ex = se;
    alu_src = src; reg_dst = rd; m_in = m; wb_in = wb; pc_in = pc; flush = fl;
  endtask

  initial begin
    rst = 1'b0;
    dest1 = 5'd5; dest2 = 5'd9;
    drive(1, 3'b000, 32'd3, 32'd4, 32'd0, 0, 0, 1, 2'd2, 32'h100, 0);
    repeat (3) step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_result", alu_result, 32'd0);
    chk("rst_wb", {30'd0, wb_out}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);

    rst = 1'b1;
    step();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", alu_result, 32'd7);
    chk("add_dest", {27'd0, dest_out}, 32'd5);
    chk("add_pc", pc_out, 32'h100);
    chk("add_m", {31'd0, m_out}, 32'd1);
    chk("add_wb", {30'd0, wb_out}, 32'd2);
    chk("add_store", store_data, 32'd4);

    drive(1, 3'b001, 32'd5, 32'd7, 32'd0, 0, 0, 0, 2'd1, 32'h104, 0);
    step();
    chk("sub_result", alu_result, 32'hFFFF_FFFE);
    drive(1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 0, 2'd1, 32'h108, 0);
    step();
    chk("slt_result", alu_result, 32'd1);
    drive(1, 3'b110, 32'd1, 32'd31, 32'd0, 0, 0, 0, 2'd1, 32'h10C, 0);
    step();
    chk("sll_result", alu_result, 32'h8000_0000);
    drive(1, 3'b000, 32'd10, 32'd100, 32'hFFFF_FFFF, 1, 1, 0, 2'd1, 32'h110, 0);
    step();
    chk("imm_result", alu_result, 32'd9);
    chk("imm_dest2", {27'd0, dest_out}, 32'd9);
    drive(1, 3'b100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 0, 0, 0, 2'd1, 32'h114, 0);
    step();
    chk("xor_result", alu_result, 32'hFF00_0FF0);

    drive(0, 3'b000, 32'd1, 32'd1, 32'd0, 0, 0, 1, 2'd3, 32'h118, 0);
    step();
    chk("bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("bubble_m", {31'd0, m_out}, 32'd0);
    chk("bubble_wb", {30'd0, wb_out}, 32'd0);

    // MUL 0xFFFF * 0x10001, then an ADD waits behind it.
    drive(1, 3'b111, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 0, 0, 0, 2'd1, 32'h200, 0);
    step();
    chk("mul_stall0", {31'd0, stall}, 32'd1);
    chk("mul_valid0", {31'd0, out_valid}, 32'd0);
    drive(1, 3'b000, 32'd1, 32'd1, 32'd0, 0, 1, 1, 2'd3, 32'h204, 0);
    cnt = 1;
    for (int i = 1; i < 32; i++) begin
      step();
      if (stall && !out_valid) cnt++;
    end
    chk("mul_stall_cycles", cnt, 32'd32);
    step();
    chk("mul_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_result", alu_result, 32'hFFFF_FFFF);
    chk("mul_stall_end", {31'd0, stall}, 32'd0);
    chk("mul_pc", pc_out, 32'h200);
    chk("mul_dest", {27'd0, dest_out}, 32'd5);
    chk("mul_wb", {30'd0, wb_out}, 32'd1);
    step();
    chk("post_mul_add_valid", {31'd0, out_valid}, 32'd1);
    chk("post_mul_add", alu_result, 32'd2);
    chk("post_mul_pc", pc_out, 32'h204);

    // Flush on MUL cycle 10.
    drive(1, 3'b111, 32'd3, 32'd5, 32'd0, 0, 0, 0, 2'd1, 32'h300, 0);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("flush_pre_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    step();
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    cnt = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      if (out_valid || stall) cnt++;
    end
    chk("flush_no_result", cnt, 32'd0);

    drive(1, 3'b000, 32'd20, 32'd22, 32'd0, 0, 0, 0, 2'd1, 32'h400, 0);
    step();
    chk("pre_flush_add", alu_result, 32'd42);
    drive(1, 3'b000, 32'd1, 32'd2, 32'd0, 0, 0, 1, 2'd2, 32'h404, 1);
    step();
    chk("flush_add_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_add_hold", alu_result, 32'd42);

    // Reset asserted on MUL cycle 20.
    drive(1, 3'b111, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 0, 0, 1, 2'd3, 32'h500, 0);
    step();
    in_valid = 1'b0;
    repeat (19) step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", alu_result, 32'd0);
    chk("midrst_pc", pc_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid || stall) cnt++;
    end
    chk("midrst_no_result", cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
